// File: rtl/gpio_cfg_pkg.sv
// Shared constants and types for the GPIO pad configuration sequencer.
// Pad mode words, address width and the chain-shifting FSM state encoding.
package gpio_cfg_pkg;

  localparam int CFG_W     = 13;
  localparam int MAX_PADS  = 38;
  localparam int ADDR_W    = $clog2(MAX_PADS);
  localparam int BIT_W     = $clog2(CFG_W);

  // Pad mode words: management standard input (reset), management output, user bidir
  localparam logic [CFG_W-1:0] CFG_RESET      = 13'h0403;
  localparam logic [CFG_W-1:0] CFG_MGMT_OUT   = 13'h1809;
  localparam logic [CFG_W-1:0] CFG_USER_BIDIR = 13'h1801;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_HI,
    LOAD,
    DONE
  } state_t;

endpackage

// File: rtl/gpio_cfg_bit_timer.sv
// Phase timer for the serial chain: counts CLK_DIV cycles while run is high
// and flags the last cycle of each phase so the FSM can move on.
module gpio_cfg_bit_timer
  import gpio_cfg_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic run,
  output logic phase_end
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_reg;

  assign phase_end = run && (count_reg == LAST);

  // Restarting on phase_end keeps every phase exactly CLK_DIV cycles long.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_reg <= '0;
    end else if (!run || phase_end) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/gpio_cfg_sequencer.sv
// Per-pad configuration store that serially loads both mprj_io control-block
// chains in lockstep, MSB first, finishing with a parallel-load strobe.
module gpio_cfg_sequencer
  import gpio_cfg_pkg::*;
#(
  parameter int AREA1PADS  = 19,
  parameter int TOTAL_PADS = 38,
  parameter int CLK_DIV    = 2,
  parameter int AUTO_LOAD  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_wdata,
  output logic [CFG_W-1:0]  cfg_rdata,
  output logic              cfg_err,
  input  logic              xfer_start,
  output logic              busy,
  output logic              done,
  output logic              serial_clock,
  output logic              serial_load,
  output logic              serial_resetn,
  output logic              serial_data_1,
  output logic              serial_data_2
);

  localparam int AREA2PADS = TOTAL_PADS - AREA1PADS;
  localparam int MAXP      = (AREA1PADS > AREA2PADS) ? AREA1PADS : AREA2PADS;
  localparam int PAD1      = MAXP - AREA1PADS;
  localparam int PAD2      = MAXP - AREA2PADS;
  localparam int SLOT_W    = $clog2(MAXP + 1);

  localparam logic [ADDR_W-1:0] NPADS     = ADDR_W'(TOTAL_PADS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(MAXP - 1);
  localparam logic [BIT_W-1:0]  TOP_BIT   = BIT_W'(CFG_W - 1);

  logic [CFG_W-1:0]  words [TOTAL_PADS];
  state_t            state_reg;
  logic [SLOT_W-1:0] slot_reg;
  logic [BIT_W-1:0]  bit_reg;
  logic              auto_req_reg;

  logic              run;
  logic              phase_end;
  logic              start;
  logic              addr_ok;
  logic              last_bit;
  logic [SLOT_W-1:0] slot_next;
  logic [BIT_W-1:0]  bit_next;
  logic              data1_next;
  logic              data2_next;

  assign run      = state_reg inside {SETUP, CLK_HI, LOAD};
  assign start    = xfer_start | auto_req_reg;
  assign addr_ok  = cfg_addr < NPADS;
  assign last_bit = (slot_reg == LAST_SLOT) && (bit_reg == '0);

  gpio_cfg_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk      (clk),
    .resetn   (resetn),
    .run      (run),
    .phase_end(phase_end)
  );

  // Next slot/bit and the data bit each chain presents for it. Chain 1 walks
  // pads downward from the top of area1, chain 2 upward from the bottom of area2.
  always_comb begin
    int s;
    slot_next  = '0;
    bit_next   = TOP_BIT;
    data1_next = 1'b0;
    data2_next = 1'b0;
    if (state_reg != IDLE) begin
      if (bit_reg == '0) begin
        slot_next = slot_reg + SLOT_W'(1);
      end else begin
        slot_next = slot_reg;
        bit_next  = bit_reg - BIT_W'(1);
      end
    end
    s = int'(slot_next);
    if (s >= PAD1 && s < MAXP) begin
      data1_next = words[ADDR_W'(MAXP - 1 - s)][bit_next];
    end
    if (s >= PAD2 && s < MAXP) begin
      data2_next = words[ADDR_W'(AREA1PADS - PAD2 + s)][bit_next];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TOTAL_PADS; i++) begin
        words[i] <= CFG_RESET;
      end
      cfg_rdata <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err   <= cfg_we & (busy | ~addr_ok);
      cfg_rdata <= addr_ok ? words[cfg_addr] : '0;
      if (cfg_we && !busy && addr_ok) begin
        words[cfg_addr] <= cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      slot_reg      <= '0;
      bit_reg       <= '0;
      auto_req_reg  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      serial_clock  <= 1'b0;
      serial_load   <= 1'b0;
      serial_data_1 <= 1'b0;
      serial_data_2 <= 1'b0;
      serial_resetn <= 1'b0;
    end else begin
      serial_resetn <= 1'b1;
      // serial_resetn still low marks the first edge after release
      auto_req_reg  <= (AUTO_LOAD != 0) && !serial_resetn;
      done          <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= SETUP;
            busy          <= 1'b1;
            slot_reg      <= slot_next;
            bit_reg       <= bit_next;
            serial_data_1 <= data1_next;
            serial_data_2 <= data2_next;
          end
        end
        SETUP: begin
          if (phase_end) begin
            state_reg    <= CLK_HI;
            serial_clock <= 1'b1;
          end
        end
        CLK_HI: begin
          if (phase_end) begin
            serial_clock <= 1'b0;
            if (last_bit) begin
              state_reg     <= LOAD;
              serial_load   <= 1'b1;
              serial_data_1 <= 1'b0;
              serial_data_2 <= 1'b0;
            end else begin
              state_reg     <= SETUP;
              slot_reg      <= slot_next;
              bit_reg       <= bit_next;
              serial_data_1 <= data1_next;
              serial_data_2 <= data2_next;
            end
          end
        end
        LOAD: begin
          if (phase_end) begin
            state_reg   <= DONE;
            serial_load <= 1'b0;
            done        <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
